// File: rtl/wb_bram_pkg.sv
// Shared definitions for the Wishbone-to-BRAM bridge: FSM encoding,
// parameter defaults and the byte-address to word-index mapping.
package wb_bram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    localparam int unsigned DELAYS_DEFAULT    = 10;
    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h3800_0000;
    localparam int unsigned CNT_W             = 8;

    // The BRAM is word addressed; only the 22 word bits inside the 16 MiB region matter.
    function automatic logic [31:0] word_index(input logic [21:0] word);
        return {10'b0, word};
    endfunction

endpackage

// File: rtl/wb_wait_cnt.sv
// Wait-state down-counter: loadable, decrements towards zero and reports
// when it is on its final wait cycle or already exhausted.
module wb_wait_cnt
    import wb_bram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign zero = (cnt_reg == '0);
    assign last = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave bridging single-word transfers onto a registered-output
// BRAM port, with a programmable number of wait states before each access.
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter int unsigned DELAYS    = DELAYS_DEFAULT,
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_di,
    input  logic [31:0] bram_do
);

    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAYS);
    localparam bit               NO_WAIT    = (DELAYS == 0);

    state_t      state_reg;
    logic        we_reg;
    logic [3:0]  sel_reg;
    logic        drop_reg;

    logic        req_hit;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic        cnt_last;
    logic [3:0]  req_we_lanes;
    logic [3:0]  lat_we_lanes;
    logic [1:0]  adr_unused;

    assign adr_unused = wbs_adr_i[1:0];
    assign req_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == ADDR_BASE[31:24]);
    assign cnt_load   = (state_reg == ST_IDLE) && req_hit;
    assign cnt_dec    = (state_reg == ST_WAIT) && wbs_cyc_i;

    // Reads drive all lanes low; writes pass the selected lanes through.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign req_we_lanes[gi] = wbs_we_i & wbs_sel_i[gi];
        assign lat_we_lanes[gi] = we_reg & sel_reg[gi];
    end

    wb_wait_cnt u_wait_cnt (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (cnt_load),
        .load_val (DELAY_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            drop_reg  <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_di   <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            bram_en   <= 1'b0;
            bram_we   <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_hit) begin
                        we_reg    <= wbs_we_i;
                        sel_reg   <= wbs_sel_i;
                        bram_di   <= wbs_dat_i;
                        bram_addr <= word_index(wbs_adr_i[23:2]);
                        drop_reg  <= 1'b0;
                        if (NO_WAIT) begin
                            state_reg <= ST_ACCESS;
                            bram_en   <= 1'b1;
                            bram_we   <= req_we_lanes;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Abort wins over the final wait cycle so a dropped cycle never reaches the BRAM.
                    if (!wbs_cyc_i) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_last || cnt_zero) begin
                        state_reg <= ST_ACCESS;
                        bram_en   <= 1'b1;
                        bram_we   <= lat_we_lanes;
                    end
                end
                ST_ACCESS: begin
                    drop_reg  <= !wbs_cyc_i;
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (drop_reg || !wbs_cyc_i) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= we_reg ? 32'h0 : bram_do;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: one instance with 4 wait states, one with none,
// each attached to a simple registered-output BRAM.
module tb_wb_bram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [3:0]  sel   [2];
    logic [31:0] adr   [2];
    logic [31:0] dati  [2];
    logic        ack   [2];
    logic [31:0] dato  [2];
    logic        ben   [2];
    logic [3:0]  bwe   [2];
    logic [31:0] baddr [2];
    logic [31:0] bdi   [2];
    logic [31:0] bdo   [2];

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] mem [0:255];
        logic [31:0] do_q = '0;

        wb_bram_ctrl #(.DELAYS(gi == 0 ? 4 : 0)) u_dut (
            .wb_clk_i  (clk),
            .wb_rst_i  (rst),
            .wbs_cyc_i (cyc[gi]),
            .wbs_stb_i (stb[gi]),
            .wbs_we_i  (we[gi]),
            .wbs_sel_i (sel[gi]),
            .wbs_adr_i (adr[gi]),
            .wbs_dat_i (dati[gi]),
            .wbs_ack_o (ack[gi]),
            .wbs_dat_o (dato[gi]),
            .bram_en   (ben[gi]),
            .bram_we   (bwe[gi]),
            .bram_addr (baddr[gi]),
            .bram_di   (bdi[gi]),
            .bram_do   (bdo[gi])
        );

        // Registered-output BRAM: data appears one cycle after the enable, zero otherwise.
        always @(posedge clk) begin
            if (ben[gi] === 1'b1) begin
                for (int b = 0; b < 4; b++)
                    if (bwe[gi][b]) mem[baddr[gi][7:0]][8*b +: 8] <= bdi[gi][8*b +: 8];
                do_q <= mem[baddr[gi][7:0]];
            end else begin
                do_q <= '0;
            end
        end
        assign bdo[gi] = do_q;
    end

    // Model state: what each instance must show, and on which cycle.
    int          exp_en_cyc  [2];
    logic [3:0]  exp_en_we   [2];
    logic [31:0] exp_en_addr [2];
    logic [31:0] exp_en_di   [2];
    int          exp_ack_cyc [2];
    logic [31:0] exp_ack_dat [2];
    logic [31:0] mdl_mem     [2][256];
    int          en_count    [2];
    logic [31:0] last_en_addr[2];
    logic [3:0]  last_en_we  [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc_n);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic ea;
            logic ee;
            ea = (exp_ack_cyc[i] == cyc_n);
            ee = (exp_en_cyc[i] == cyc_n);
            chk($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(ea));
            if (ea) chk($sformatf("dat_o[%0d]", i), dato[i], exp_ack_dat[i]);
            chk($sformatf("bram_en[%0d]", i), 32'(ben[i]), 32'(ee));
            chk($sformatf("bram_we[%0d]", i), 32'(bwe[i]), ee ? 32'(exp_en_we[i]) : 32'h0);
            if (ee) begin
                chk($sformatf("bram_addr[%0d]", i), baddr[i], exp_en_addr[i]);
                chk($sformatf("bram_di[%0d]", i), bdi[i], exp_en_di[i]);
            end
            if (ben[i] === 1'b1) begin
                en_count[i]++;
                last_en_addr[i] = baddr[i];
                last_en_we[i]   = bwe[i];
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s ack[%0d]", tag, i), 32'(ack[i]), 32'h0);
            chk($sformatf("%s dat_o[%0d]", tag, i), dato[i], 32'h0);
            chk($sformatf("%s bram_en[%0d]", tag, i), 32'(ben[i]), 32'h0);
            chk($sformatf("%s bram_we[%0d]", tag, i), 32'(bwe[i]), 32'h0);
            chk($sformatf("%s bram_addr[%0d]", tag, i), baddr[i], 32'h0);
            chk($sformatf("%s bram_di[%0d]", tag, i), bdi[i], 32'h0);
        end
    endtask

    // drop: 0 = hold cycle until ack, 1 = drop cyc during WAIT, 2 = drop cyc during CAPTURE.
    task automatic xfer(input int i, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input int drop,
                        output int lat, output logic [31:0] rd, output int npulse);
        int          dly;
        int          r;
        int          base;
        int          bound;
        logic [31:0] word;
        logic        hit;
        dly = (i == 0) ? 4 : 0;
        tick();
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; sel[i] = s; adr[i] = a; dati[i] = d;
        r     = cyc_n + 1;
        base  = en_count[i];
        hit   = ((a / 32'h0100_0000) == 32'h38);
        word  = (a % 32'h0100_0000) / 4;
        lat   = -1;
        rd    = '0;
        if (hit && drop != 1) begin
            exp_en_cyc[i]  = r + dly;
            exp_en_we[i]   = w ? s : 4'h0;
            exp_en_addr[i] = word;
            exp_en_di[i]   = d;
        end
        if (hit && drop == 0) begin
            exp_ack_cyc[i] = r + dly + 2;
            exp_ack_dat[i] = w ? 32'h0 : mdl_mem[i][word[7:0]];
        end
        if (hit && drop != 1 && w)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl_mem[i][word[7:0]][8*b +: 8] = d[8*b +: 8];
        bound = (hit && drop == 0) ? dly + 10 : 50;
        for (int n = 0; n < bound; n++) begin
            tick();
            if (ack[i] === 1'b1) begin
                lat = cyc_n + 1 - r;
                rd  = dato[i];
                break;
            end
            if ((drop == 1 && cyc_n == r + 1) || (drop == 2 && cyc_n == r + dly + 1)) begin
                cyc[i] = 1'b0;
                stb[i] = 1'b0;
            end
        end
        cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; sel[i] = '0; adr[i] = '0; dati[i] = '0;
        npulse = en_count[i] - base;
        $display("xfer dut%0d %s adr=%h sel=%h dat=%h drop=%0d -> latency=%0d rdata=%h en_pulses=%0d",
                 i, w ? "WR" : "RD", a, s, d, drop, lat, rd, npulse);
    endtask

    initial begin
        int          lat;
        int          np;
        logic [31:0] rd;
        int          r;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; sel[i] = '0; adr[i] = '0; dati[i] = '0;
            exp_en_cyc[i] = -1; exp_ack_cyc[i] = -1; en_count[i] = 0;
            exp_en_we[i] = '0; exp_en_addr[i] = '0; exp_en_di[i] = '0; exp_ack_dat[i] = '0;
            last_en_addr[i] = '0; last_en_we[i] = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Four wait states: full write, read-back, partial write, read-back.
        xfer(0, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 0, lat, rd, np);
        chk("wr latency", lat, 7);
        chk("wr en pulses", np, 1);
        chk("wr bram_addr", last_en_addr[0], 32'd4);
        chk("wr bram_we", 32'(last_en_we[0]), 32'hF);
        xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 0, lat, rd, np);
        chk("rd data", rd, 32'hDEAD_BEEF);
        chk("rd latency", lat, 7);
        xfer(0, 1'b1, 4'b0010, 32'h3800_0010, 32'h0000_5500, 0, lat, rd, np);
        chk("partial wr bram_we", 32'(last_en_we[0]), 32'h2);
        xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 0, lat, rd, np);
        chk("partial rd data", rd, 32'hDEAD_55EF);

        // Outside the decode region: silence for 50 cycles.
        xfer(0, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 0, lat, rd, np);
        chk("miss latency", lat, -1);
        chk("miss en pulses", np, 0);

        // No wait states, back-to-back.
        xfer(1, 1'b1, 4'hF, 32'h3800_0000, 32'h1111_1111, 0, lat, rd, np);
        xfer(1, 1'b1, 4'hF, 32'h3800_0004, 32'h2222_2222, 0, lat, rd, np);
        xfer(1, 1'b0, 4'hF, 32'h3800_0000, 32'h0, 0, lat, rd, np);
        chk("d0 rd0 data", rd, 32'h1111_1111);
        chk("d0 rd0 latency", lat, 3);
        chk("d0 rd0 en pulses", np, 1);
        xfer(1, 1'b0, 4'hF, 32'h3800_0004, 32'h0, 0, lat, rd, np);
        chk("d0 rd1 data", rd, 32'h2222_2222);
        chk("d0 rd1 latency", lat, 3);
        chk("d0 rd1 en pulses", np, 1);

        // Aborts.
        xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 1, lat, rd, np);
        chk("wait abort latency", lat, -1);
        chk("wait abort en pulses", np, 0);
        xfer(0, 1'b1, 4'hF, 32'h3800_0014, 32'h1234_5678, 2, lat, rd, np);
        chk("capture abort latency", lat, -1);
        chk("capture abort en pulses", np, 1);
        xfer(0, 1'b0, 4'hF, 32'h3800_0014, 32'h0, 0, lat, rd, np);
        chk("capture abort data landed", rd, 32'h1234_5678);

        // Write with no lanes selected.
        xfer(0, 1'b1, 4'h0, 32'h3800_0010, 32'hFFFF_FFFF, 0, lat, rd, np);
        chk("sel0 latency", lat, 7);
        chk("sel0 en pulses", np, 1);
        chk("sel0 bram_we", 32'(last_en_we[0]), 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 0, lat, rd, np);
        chk("sel0 data kept", rd, 32'hDEAD_55EF);

        // Reset in the middle of a WAIT.
        tick();
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; adr[0] = 32'h3800_0014; dati[0] = '0;
        r = cyc_n + 1;
        exp_en_cyc[0] = r + 4; exp_en_we[0] = 4'h0; exp_en_addr[0] = 32'd5; exp_en_di[0] = '0;
        exp_ack_cyc[0] = r + 6; exp_ack_dat[0] = 32'h1234_5678;
        tick();
        tick();
        chk("pre-reset bram_addr", baddr[0], 32'd5);
        #3;
        rst = 1'b1;
        exp_en_cyc[0] = -1; exp_ack_cyc[0] = -1; exp_en_cyc[1] = -1; exp_ack_cyc[1] = -1;
        #1;
        check_zero("async reset");
        $display("xfer dut0 RD adr=38000014 interrupted by reset in WAIT");
        cyc[0] = 1'b0; stb[0] = 1'b0; sel[0] = '0; adr[0] = '0;
        tick();
        tick();
        rst = 1'b0;
        xfer(0, 1'b0, 4'hF, 32'h3800_0014, 32'h0, 0, lat, rd, np);
        chk("post-reset rd data", rd, 32'h1234_5678);
        chk("post-reset latency", lat, 7);
        chk("post-reset en pulses", np, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
